// File: rtl/mux_sel_pair.sv
// Registered 4:1 + 2:1 select pair with combinational and registered result per lane.
// Optional build macro MUX_CASCADE_EN feeds the 4:1 result into the 2:1 lane's in0 operand.
module mux_sel_pair #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] m4_in0,
    input  logic [WIDTH-1:0] m4_in1,
    input  logic [WIDTH-1:0] m4_in2,
    input  logic [WIDTH-1:0] m4_in3,
    input  logic [1:0]       m4_sel,
    input  logic [WIDTH-1:0] m2_in0,
    input  logic [WIDTH-1:0] m2_in1,
    input  logic             m2_sel,
    output logic [WIDTH-1:0] m4_out,
    output logic [WIDTH-1:0] m2_out,
    output logic [WIDTH-1:0] m4_q,
    output logic [WIDTH-1:0] m2_q
);

    logic [WIDTH-1:0] m2_op0;
    logic [WIDTH-1:0] m4_d;
    logic [WIDTH-1:0] m2_d;

    // NOTE: the default arm makes the case full, so no latch is inferred for any select value.
    always_comb begin
        case (m4_sel)
            2'b00:   m4_out = m4_in0;
            2'b01:   m4_out = m4_in1;
            2'b10:   m4_out = m4_in2;
            default: m4_out = m4_in3;
        endcase
    end

`ifdef MUX_CASCADE_EN
    // Cascading makes two instances an 8:1 select with m2_sel as the MSB.
    assign m2_op0 = m4_out;
`else
    assign m2_op0 = m2_in0;
`endif

    assign m2_out = m2_sel ? m2_in1 : m2_op0;

    always_comb begin
        m4_d = m4_q;
        m2_d = m2_q;
        if (rst) begin
            m4_d = '0;
            m2_d = '0;
        end else if (en) begin
            m4_d = m4_out;
            m2_d = m2_out;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        m4_q <= m4_d;
        m2_q <= m2_d;
    end

endmodule

// File: tb/tb_mux_sel_pair.sv
// Scoreboard bench for mux_sel_pair: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_mux_sel_pair;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic [W-1:0] m4_in0 = '0, m4_in1 = '0, m4_in2 = '0, m4_in3 = '0;
    logic [1:0]   m4_sel = '0;
    logic [W-1:0] m2_in0 = '0, m2_in1 = '0;
    logic         m2_sel = 1'b0;
    logic [W-1:0] m4_out, m2_out, m4_q, m2_q;

    mux_sel_pair #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .m4_in0(m4_in0), .m4_in1(m4_in1), .m4_in2(m4_in2), .m4_in3(m4_in3),
        .m4_sel(m4_sel),
        .m2_in0(m2_in0), .m2_in1(m2_in1), .m2_sel(m2_sel),
        .m4_out(m4_out), .m2_out(m2_out), .m4_q(m4_q), .m2_q(m2_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] m4o;
        logic [W-1:0] m2o;
        logic [W-1:0] m4q;
        logic [W-1:0] m2q;
        bit           q_known;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference register contents, advanced once per issued cycle.
    logic [W-1:0] mdl_m4q = '0;
    logic [W-1:0] mdl_m2q = '0;
    bit           mdl_known = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("m4_out", m4_out, e.m4o);
            check("m2_out", m2_out, e.m2o);
            if (e.q_known) begin
                check("m4_q", m4_q, e.m4q);
                check("m2_q", m2_q, e.m2q);
            end
        end
    end

    task automatic apply(input bit r, input bit e, input logic [1:0] s4,
                         input logic [W-1:0] a0, input logic [W-1:0] a1,
                         input logic [W-1:0] a2, input logic [W-1:0] a3,
                         input bit s2, input logic [W-1:0] b0, input logic [W-1:0] b1);
        logic [W-1:0] ins [4];
        logic [W-1:0] sel4v, sel2v;
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; en = e; m4_sel = s4; m2_sel = s2;
        m4_in0 = a0; m4_in1 = a1; m4_in2 = a2; m4_in3 = a3;
        m2_in0 = b0; m2_in1 = b1;
        ins = '{a0, a1, a2, a3};
        sel4v = ins[s4];
`ifdef MUX_CASCADE_EN
        sel2v = s2 ? b1 : sel4v;
`else
        sel2v = s2 ? b1 : b0;
`endif
        x = '{sel4v, sel2v, mdl_m4q, mdl_m2q, mdl_known};
        sb.push_back(x);
        if (r) begin
            mdl_m4q = '0; mdl_m2q = '0; mdl_known = 1'b1;
        end else if (e) begin
            mdl_m4q = sel4v; mdl_m2q = sel2v; mdl_known = 1'b1;
        end
    endtask

    initial begin
        logic [W-1:0] v [4];
        apply(1, 0, 2'd0, '0, '0, '0, '0, 0, '0, '0);
        apply(1, 1, 2'd1, 8'h11, 8'h22, 8'h33, 8'h44, 1, 8'h55, 8'h66);

        // One-hot sweep, then inverted one-hot.
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 4; k++) v[k] = (k == s) ? 8'hFF : 8'h00;
            apply(0, 1, 2'(s), v[0], v[1], v[2], v[3], 0, '0, '0);
        end
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 4; k++) v[k] = (k == s) ? 8'h00 : 8'hFF;
            apply(0, 1, 2'(s), v[0], v[1], v[2], v[3], 0, '0, '0);
        end

        // 2:1 lane directed values.
        apply(0, 1, 2'd0, '0, '0, '0, '0, 0, 8'hA5, 8'h3C);
        apply(0, 1, 2'd0, '0, '0, '0, '0, 1, 8'hA5, 8'h3C);

        // All-zeros and all-ones across every select code.
        for (int s = 0; s < 8; s++)
            apply(0, 1, 2'(s), '0, '0, '0, '0, s[2], '0, '0);
        for (int s = 0; s < 8; s++)
            apply(0, 1, 2'(s), '1, '1, '1, '1, s[2], '1, '1);

        // Reset clears FF registers while the combinational path keeps following.
        apply(0, 1, 2'd1, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1, 8'h5A, 8'h5A);
        apply(1, 1, 2'd1, 8'h01, 8'hC3, 8'h02, 8'h03, 0, 8'h96, 8'h00);
        apply(0, 0, 2'd2, 8'h01, 8'hC3, 8'h02, 8'h03, 0, 8'h96, 8'h00);

        // Enable hold then release.
        apply(0, 1, 2'd0, 8'h11, 8'h00, 8'h00, 8'h00, 0, 8'h22, 8'h00);
        repeat (3) apply(0, 0, 2'd3, 8'h11, 8'h00, 8'h00, 8'h77, 1, 8'h22, 8'h99);
        apply(0, 1, 2'd3, 8'h11, 8'h00, 8'h00, 8'h77, 1, 8'h22, 8'h99);

        // A reset pulse entirely between edges must not touch the registers.
        apply(0, 0, 2'd3, 8'h11, 8'h00, 8'h00, 8'h77, 1, 8'h22, 8'h99);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        apply(0, 0, 2'd1, 8'h11, 8'h00, 8'h00, 8'h77, 0, 8'h22, 8'h99);

        // Cascade scenario; the model picks the right operand for either build.
        apply(0, 1, 2'd2, 8'h00, 8'h00, 8'h01, 8'h00, 0, 8'h80, 8'h00);
        apply(0, 1, 2'd2, 8'h00, 8'h00, 8'h01, 8'h00, 1, 8'h80, 8'h00);

        for (int i = 0; i < 300; i++)
            apply(($urandom_range(19) == 0), ($urandom_range(3) != 0), 2'($urandom),
                  W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                  1'($urandom), W'($urandom), W'($urandom));
        apply(0, 0, 2'd0, '0, '0, '0, '0, 0, '0, '0);

        for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_sel_pair.md
Name: mux_sel_pair

Overview:
- Registered selection block holding one 4:1 multiplexer lane and one 2:1 multiplexer lane, each WIDTH bits wide.
- Serves as the leaf-level select primitive. Wider trees (e.g. 8:1) are built by feeding two 4:1 results into a 2:1 stage.
- Each lane has a combinational select path and a registered output.

Parameters:
- WIDTH, 1, data width of every mux input and output.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  register load enable; applies to both lanes.
- m4_in0  input  WIDTH  4:1 lane input, selected by m4_sel=0.
- m4_in1  input  WIDTH  4:1 lane input, selected by m4_sel=1.
- m4_in2  input  WIDTH  4:1 lane input, selected by m4_sel=2.
- m4_in3  input  WIDTH  4:1 lane input, selected by m4_sel=3.
- m4_sel  input  2  4:1 lane select; bit 1 is the MSB.
- m2_in0  input  WIDTH  2:1 lane input, selected by m2_sel=0.
- m2_in1  input  WIDTH  2:1 lane input, selected by m2_sel=1.
- m2_sel  input  1  2:1 lane select.
- m4_out  output  WIDTH  combinational 4:1 result.
- m2_out  output  WIDTH  combinational 2:1 result.
- m4_q  output  WIDTH  registered 4:1 result.
- m2_q  output  WIDTH  registered 2:1 result.

Behaviour:
- 4:1 lane select mapping:
  - m4_out = m4_in0 / m4_in1 / m4_in2 / m4_in3 for m4_sel = 00 / 01 / 10 / 11.
  - Pure combinational path, zero latency, no glitch filtering.
- 2:1 lane select mapping:
  - m2_out = m2_in0 when m2_sel=0, m2_in1 when m2_sel=1.
  - Zero latency.
- Selection is per-bit identical across WIDTH; no arithmetic.
- Unknown or X select values carry no defined requirement; synthesis treats the select as a full case, with no latch.
- Registered outputs:
  - On each rising clk edge with rst=1: m4_q and m2_q load all zeros, regardless of en.
  - With rst=0 and en=1: m4_q <= m4_out and m2_q <= m2_out, giving 1-cycle latency.
  - With rst=0 and en=0: both registers hold their value.
- Reset is synchronous only:
  - Asserting rst between edges has no effect until the next edge.
  - The combinational outputs are never affected by rst.
- Reset mid-operation: the first edge with rst=1 clears the registers. The first edge after rst deasserts with en=1 captures the current selection.
- Both lanes are fully independent; simultaneous select changes on both lanes are legal.
- Power-up register values are undefined until the first reset edge.

Optional Feature:
- Macro: MUX_CASCADE_EN.
- When defined:
  - The 2:1 lane's in0 operand is the internal 4:1 combinational result m4_out, replacing the m2_in0 port value. The m2_in0 port remains present but unused.
  - m2_out therefore equals m4_out when m2_sel=0, else m2_in1.
  - This allows two instances to form an 8:1 select, with m2_sel acting as the select MSB.
- When not defined: lanes are independent exactly as described in Behaviour.

Test Plan:
- One-hot sweep, WIDTH=1, en=1, rst=0:
  - For each m4_sel 0..3, drive the selected input 1 and the others 0 -> m4_out=1 immediately and m4_q=1 one cycle later.
  - Repeat with the selected input 0 and the others 1 -> m4_out=0 and m4_q=0.
- 2:1 lane, WIDTH=8:
  - m2_in0=8'hA5, m2_in1=8'h3C, m2_sel=0 -> m2_out=8'hA5.
  - m2_sel=1 -> m2_out=8'h3C, and m2_q=8'h3C after the next edge.
- All-zeros inputs across all select codes -> every output is 0. All-ones inputs -> every output is all ones.
- Reset:
  - Registers hold 8'hFF; assert rst for one edge with en=1 -> m4_q=m2_q=0 after that edge.
  - m4_out still follows the selected input while rst=1.
- Enable hold:
  - en=0, change m4_sel from 0 to 3 with m4_in3=8'h77 -> m4_q unchanged over 3 edges.
  - en=1 -> m4_q=8'h77 after one edge.
- With MUX_CASCADE_EN defined:
  - m4_in2=1, m4_sel=2, m2_sel=0 -> m2_out=1.
  - m2_sel=1, m2_in1=0 -> m2_out=0.
